issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// Issue stage controller: holds one decoded instruction for execute, tracks
// outstanding load destinations in a scoreboard, stalls on RAW/WAW hazards
// against those loads, and blocks issue while a branch or jump is unresolved.
module issue_ctrl #(
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic [4:0]           rd_addr,
    input  logic                 uses_rs1,
    input  logic                 uses_rs2,
    input  logic                 reg_write_en,
    input  logic                 mem_read,
    input  logic                 branch,
    input  logic                 jump,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,

    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,

    input  logic                 resolve_i,
    input  logic                 flush_i,

    output logic [31:0]          pending_o,
    output logic                 state_o,
    output logic [15:0]          stall_cnt_o
);

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StWaitBr = 1'b1
    } state_e;

    state_e                 state_q;
    logic                   out_valid_q;
    logic [PAYLOAD_W-1:0]   out_payload_q;
    logic [31:0]            pending_q, pending_d;
    logic [15:0]            stall_cnt_q;

    logic hazard;
    logic accept;
    logic stall;

    // Hazard check uses the registered scoreboard only; a writeback this cycle
    // does not release a waiting instruction until the following cycle.
    always_comb begin
        hazard = (uses_rs1     & pending_q[rs1_addr])
               | (uses_rs2     & pending_q[rs2_addr])
               | (reg_write_en & pending_q[rd_addr]);
        in_ready = (state_q == StRun) & ~flush_i & ~hazard & (~out_valid_q | out_ready);
        accept   = in_valid & in_ready;
        stall    = in_valid & ~in_ready;
    end

    // Scoreboard next state: clear on writeback, then set on load accept so a
    // same-cycle set wins; x0 never becomes pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (accept && mem_read && reg_write_en && (rd_addr != 5'd0)) begin
            pending_d[rd_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Issue register: flush cannot coincide with accept since in_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_payload_q <= in_payload;
        end else if (flush_i || out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    // Branch-wait FSM: flush redirects back to RUN unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else if (flush_i) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (accept && (branch || jump)) begin
                        state_q <= StWaitBr;
                    end
                end
                StWaitBr: begin
                    if (resolve_i) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Scoreboard register; flush leaves it alone because loads still return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Saturating count of cycles an offered instruction was held back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_payload = out_payload_q;
    assign pending_o   = pending_q;
    assign state_o     = (state_q == StWaitBr);
    assign stall_cnt_o = stall_cnt_q;

endmodule
